// File: rtl/fetch_stage_if.sv
// fetch_stage_if: IF-stage control, load port and IF/ID outputs.
// FETCH_PERF_CNT_EN adds the FetchCount/FlushCount outputs.
interface fetch_stage_if #(parameter int ADDR_W = 8);
    logic              Stall;
    logic              PCSrc;
    logic [31:0]       NextAddress;
    logic              ImemWrEn;
    logic [ADDR_W-1:0] ImemWrAddr;
    logic [31:0]       ImemWrData;
    logic [31:0]       Instruction;
    logic [31:0]       InputAddress;
    logic              Valid;
    logic              Halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]       FetchCount;
    logic [31:0]       FlushCount;
    modport master (output Stall, PCSrc, NextAddress, ImemWrEn, ImemWrAddr, ImemWrData,
                    input Instruction, InputAddress, Valid, Halted, FetchCount, FlushCount);
    modport slave (input Stall, PCSrc, NextAddress, ImemWrEn, ImemWrAddr, ImemWrData,
                   output Instruction, InputAddress, Valid, Halted, FetchCount, FlushCount);
`else
    modport master (output Stall, PCSrc, NextAddress, ImemWrEn, ImemWrAddr, ImemWrData,
                    input Instruction, InputAddress, Valid, Halted);
    modport slave (input Stall, PCSrc, NextAddress, ImemWrEn, ImemWrAddr, ImemWrData,
                   output Instruction, InputAddress, Valid, Halted);
`endif
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage with PC, internal imem, IF/ID register and RUN/HALT FSM.
// Define FETCH_PERF_CNT_EN to add saturating FetchCount/FlushCount outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 256,
    parameter int          ADDR_W     = 8,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input logic          Clk,
    input logic          Reset,
    fetch_stage_if.slave bus
);
    typedef enum logic {RUN, HALT} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, addr_q, addr_d, fetched;
    logic        valid_q, valid_d, load, flush;
    logic [31:0] mem [IMEM_DEPTH];
    assign fetched = mem[pc_q[ADDR_W+1:2]];
    always_ff @(posedge Clk)
        if (bus.ImemWrEn) mem[bus.ImemWrAddr] <= bus.ImemWrData;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        load    = 1'b0;
        flush   = 1'b0;
        if (state_q == HALT) begin
            instr_d = '0;
            valid_d = 1'b0;
        end else if (!bus.Stall) begin
            if (bus.PCSrc) begin
                flush   = 1'b1;
                pc_d    = {bus.NextAddress[31:2], 2'b00};
                instr_d = '0;
                addr_d  = '0;
                valid_d = 1'b0;
            end else if (fetched == HALT_WORD) begin
                state_d = HALT;
                instr_d = '0;
                valid_d = 1'b0;
            end else begin
                load    = 1'b1;
                pc_d    = pc_q + 32'd4;
                instr_d = fetched;
                addr_d  = pc_q + 32'd4;
                valid_d = 1'b1;
            end
        end
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end
    assign bus.Instruction  = instr_q;
    assign bus.InputAddress = addr_q;
    assign bus.Valid        = valid_q;
    assign bus.Halted       = (state_q == HALT);
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;
    always_comb begin
        fetch_cnt_d = (load && fetch_cnt_q != '1) ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
        flush_cnt_d = (flush && flush_cnt_q != '1) ? flush_cnt_q + 32'd1 : flush_cnt_q;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign bus.FetchCount = fetch_cnt_q;
    assign bus.FlushCount = flush_cnt_q;
`else
    logic unused_ok;
    assign unused_ok = load ^ flush;
`endif
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; the producing end of the IF/ID interface that the decode stage consumes.
- Holds the PC and an internal word-addressed instruction memory with a bench load port.
- Registers Instruction and InputAddress (PC+4) into IF/ID.
- Applies decode-resolved redirects (PCSrc/NextAddress), hazard stalls and branch-shadow flushes, and halts on a sentinel word.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
IMEM_DEPTH, 256, instruction memory size in 32-bit words
ADDR_W, 8, word-index width; must satisfy 2**ADDR_W == IMEM_DEPTH
HALT_WORD, 32'hFFFF_FFFF, fetched sentinel that stops fetch

Ports:
Clk  in  1  clock; all state updates on posedge
Reset  in  1  synchronous, active-high reset
Stall  in  1  hazard-unit stall; hold PC and IF/ID
PCSrc  in  1  decode redirect (taken branch, j, jal, jr)
NextAddress  in  32  redirect target from decode
ImemWrEn  in  1  instruction-memory write enable (load port)
ImemWrAddr  in  ADDR_W  word index to write
ImemWrData  in  32  word to write
Instruction  out  32  IF/ID instruction; 0 (sll $0,$0,0 NOP) when not valid
InputAddress  out  32  IF/ID PC+4 of Instruction
Valid  out  1  IF/ID holds a real fetched instruction
Halted  out  1  fetch FSM in HALT

Behaviour:
- Reset (takes priority over everything):
  - PC <= RESET_PC
  - Instruction <= 0, InputAddress <= 0, Valid <= 0
  - FSM <= RUN; Halted = 0
  - Memory contents are not cleared.
- Memory read is asynchronous: fetched word = mem[PC[ADDR_W+1:2]]. Upper PC bits are ignored, so addresses wrap modulo IMEM_DEPTH words.
- Memory write is synchronous on ImemWrEn, independent of the FSM and Reset.
  - A write to the address being fetched in the same cycle: the fetch returns the old word; the new word is visible next cycle.
- FSM RUN, per posedge, priority Stall > PCSrc > halt detect > normal:
  - Stall=1: PC, Instruction, InputAddress and Valid all hold. PCSrc is ignored, because the decode decision is stale while stalled.
  - PCSrc=1: PC <= {NextAddress[31:2],2'b00}; Instruction <= 0; InputAddress <= 0; Valid <= 0. This squashes the single branch-shadow slot.
  - Fetched word == HALT_WORD: FSM <= HALT; PC holds; Instruction <= 0; Valid <= 0. The halt word never enters decode.
  - Normal: Instruction <= fetched word; InputAddress <= PC+4; Valid <= 1; PC <= PC+4. PC wraps 32'hFFFF_FFFC -> 0.
- A redirect in the same cycle as a halt word fetch: the redirect wins and the FSM stays RUN (halt word was in the shadow).
- FSM HALT:
  - PC holds; Instruction <= 0; Valid <= 0; Halted = 1.
  - Stall and PCSrc are ignored.
  - Exit only via Reset.
- Latency: the word at PC appears on Instruction one posedge after PC is presented; redirect-to-target-fetched is 1 cycle plus 1 flush bubble.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs FetchCount[31:0] and FlushCount[31:0].
  - FetchCount increments on each normal-path IF/ID load.
  - FlushCount increments on each accepted redirect (PCSrc=1, Stall=0, RUN).
  - Both clear on Reset, saturate at 32'hFFFF_FFFF, and hold in HALT and during Stall.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Load mem[0..3] = 32'h2008_0005, 32'h2009_0003, 32'h0109_5020, 32'hFFFF_FFFF; release Reset -> Instruction/InputAddress = (2008_0005, 4), (2009_0003, 8), (0109_5020, 12) on three consecutive cycles with Valid=1. Next cycle Valid=0, Instruction=0 and Halted=1, stable for 10 cycles.
- Running at PC=8, pulse PCSrc=1 with NextAddress=32'h0000_0043 -> next cycle Valid=0 and Instruction=0; the cycle after, InputAddress=32'h44 and Instruction=mem[16]. FlushCount=1 with the macro defined.
- Stall=1 for 3 cycles with PCSrc=1 asserted throughout -> IF/ID and PC are unchanged; no redirect occurs. After Stall drops, with PCSrc=0, fetch resumes at the held PC.
- HALT_WORD at mem[5] and PCSrc=1 to NextAddress=0 in the cycle PC=20 -> Halted stays 0 and fetch restarts at address 0.
- NextAddress=32'h0000_0400 with IMEM_DEPTH=256 -> the fetch returns mem[0] (wrap), InputAddress=32'h404. An ImemWrEn write to the current fetch index returns the old word that cycle and the new word next cycle.
- Assert Reset mid-run at PC=12 -> next cycle Instruction=0, Valid=0, Halted=0; PC restarts at RESET_PC and memory contents are preserved.
